// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-client arbiter and sequencer for one single-port synchronous RAM
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   cN_req/we/addr/wdata           client N request (held until cN_gnt)
//   cN_gnt, cN_done                one-cycle pulses: fields captured / transaction complete
//   cN_rdata                       last read result for client N
//   ram_cs/we/oe, ram_addr         RAM controls and address
//   ram_data                       shared bus, driven here only during a write command
// Build option: RAM_ARB_FIXED_PRIORITY_EN gives client 0 fixed priority instead of round-robin.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c0_req,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   input  logic                  c1_req,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic                  c0_gnt,
   output logic                  c0_done,
   output logic [DATA_WIDTH-1:0] c0_rdata,
   output logic                  c1_gnt,
   output logic                  c1_done,
   output logic [DATA_WIDTH-1:0] c1_rdata,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);
   typedef enum logic [1:0] {IDLE, CMD, RDWAIT, DONE} state_t;
   state_t state, state_nxt;
   logic win, win_nxt, lat_we, start;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
   assign win_nxt = ~c0_req;
`else
   logic last;
   // last = client served most recently; on a tie the other one wins
   assign win_nxt = (c0_req & c1_req) ? ~last : c1_req;
`endif
   assign start = (state == IDLE) & (c0_req | c1_req);
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = (c0_req | c1_req) ? CMD : IDLE;
         CMD:     state_nxt = lat_we ? DONE : RDWAIT;
         RDWAIT:  state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      c0_gnt   = (state == CMD) & ~win;
      c1_gnt   = (state == CMD) & win;
      c0_done  = (state == DONE) & ~win;
      c1_done  = (state == DONE) & win;
      ram_cs   = (state == CMD) | (state == RDWAIT);
      ram_we   = (state == CMD) & lat_we;
      ram_oe   = ((state == CMD) & ~lat_we) | (state == RDWAIT);
      ram_addr = lat_addr;
   end
   // the bus is only ever driven while ram_oe is low
   assign ram_data = ((state == CMD) & lat_we) ? lat_wdata : {DATA_WIDTH{1'bz}};
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win       <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         c0_rdata  <= '0;
         c1_rdata  <= '0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
         last      <= 1'b1;
`endif
      end else begin
         if (start) begin
            win       <= win_nxt;
            lat_we    <= win_nxt ? c1_we : c0_we;
            lat_addr  <= win_nxt ? c1_addr : c0_addr;
            lat_wdata <= win_nxt ? c1_wdata : c0_wdata;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
            last      <= win_nxt;
`endif
         end
         if (state == RDWAIT && win)  c1_rdata <= ram_data;
         if (state == RDWAIT && !win) c0_rdata <= ram_data;
      end
   end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

- Two-client arbiter and sequencer for one `single_port_sync_ram` instance.
- Accepts independent read/write requests from two clients and picks one per transaction, round-robin by default.
- Drives the RAM `cs`/`we`/`oe`/`addr` pins and the shared bidirectional `data` bus.
- Returns read data and a completion pulse to the client that was served.

## Interface
- `ADDR_WIDTH`, 4: RAM address width.
- `DATA_WIDTH`, 16: RAM data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `c0_req`, `c1_req`  in  1  request; hold high until `cN_gnt` is seen.
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read; held stable with `req`.
- `c0_addr`, `c1_addr`  in  `ADDR_WIDTH`  target address; held stable with `req`.
- `c0_wdata`, `c1_wdata`  in  `DATA_WIDTH`  write data; held stable with `req`.
- `c0_gnt`, `c1_gnt`  out  1  one-cycle pulse; request fields have been captured.
- `c0_done`, `c1_done`  out  1  one-cycle pulse; transaction complete.
- `c0_rdata`, `c1_rdata`  out  `DATA_WIDTH`  last read result for that client; holds until that client's next read completes.
- `ram_cs`, `ram_we`, `ram_oe`  out  1  RAM controls.
  - RAM drives `ram_data` only when `cs=1`, `we=0`, `oe=1`.
- `ram_addr`  out  `ADDR_WIDTH`  RAM address.
- `ram_data`  inout  `DATA_WIDTH`  shared bus; the arbiter drives it only during a write command.

## Operation
- FSM states: IDLE, CMD, RDWAIT, DONE.
- IDLE:
  - If any `req` is high at a rising edge, select a winner.
  - Latch the winner's `we`, `addr` and `wdata`; go to CMD.
  - Otherwise stay in IDLE.
- CMD (1 cycle):
  - Winner's `gnt` = 1.
  - `ram_cs` = 1, `ram_addr` = latched address.
  - Write: `ram_we` = 1, `ram_oe` = 0, `ram_data` = latched wdata; go to DONE.
  - Read: `ram_we` = 0, `ram_oe` = 1, `ram_data` = Z; go to RDWAIT.
- RDWAIT (1 cycle):
  - `ram_cs` = 1, `ram_we` = 0, `ram_oe` = 1, address held.
  - The RAM drives `ram_data`; capture it into the winner's `rdata` at the end of the cycle; go to DONE.
- DONE (1 cycle): winner's `done` = 1; all RAM controls 0; `ram_data` = Z; go to IDLE.
- Arbitration:
  - Round-robin on a one-bit last-served pointer.
  - On simultaneous requests, the client not served last wins; a lone requester always wins.
  - The pointer updates on entry to CMD.
- Requests are not sampled outside IDLE.
  - A `req` still high when the FSM returns to IDLE is a new transaction.
  - Clients must drop `req` by the cycle after `gnt`.
- Bus safety: the arbiter never drives `ram_data` while `ram_oe` = 1; `ram_data` is Z in every state except CMD-write.
- The loser's `gnt`, `done` and `rdata` are never disturbed.

## Timing
- Request seen high in IDLE in cycle A:
  - `gnt` in A+1.
  - Write: `done` in A+2.
  - Read: `done` and valid `rdata` in A+3.
- Throughput: one write per 3 cycles, one read per 4 cycles; at most one transaction in flight.
- Reset values:
  - State IDLE; pointer favours client 0 first.
  - All `gnt`, `done`, `ram_cs`, `ram_we`, `ram_oe` = 0.
  - `ram_addr` = 0, `c0_rdata` = `c1_rdata` = 0, `ram_data` = Z.
- Reset mid-transaction (`rst_n` low at any edge):
  - Next cycle is IDLE with reset outputs.
  - The in-flight transaction is dropped with no `done`.
  - The RAM contents of an already-issued write are not reverted.
- `req` and `rst_n` low at the same edge: reset wins; the request is not latched.

## Configuration
- `RAM_ARB_FIXED_PRIORITY_EN` defined:
  - Client 0 always wins simultaneous requests.
  - The pointer is removed.
- Not defined: round-robin as above.

## Test plan
- Reset: drive `rst_n` = 0 for 2 cycles.
  - All control outputs 0, `ram_data` = Z, both `rdata` = 0.
- Single write then read: client 0 writes `addr` 3 = 16'hA5C3, then reads `addr` 3.
  - Write: `c0_gnt` at A+1, `c0_done` at A+2.
  - Read: `c0_rdata` = 16'hA5C3 with `c0_done` at A+3.
  - `c1_gnt`, `c1_done` stay 0 throughout.
- Contention: both clients hold `req` continuously for writes to `addr` 1 and 2.
  - Grants alternate c0, c1, c0, c1, each 3 cycles apart.
  - With `RAM_ARB_FIXED_PRIORITY_EN` defined, every grant goes to c0.
- Fill/readback: client 1 writes random data to all 16 addresses, then reads them back.
  - Each `c1_rdata` matches its write data; address 15 is followed by address 0 with no aliasing.
- Bus contention check: across all scenarios, `ram_data` is never driven by the arbiter while `ram_oe` = 1.
  - The bus is never X during RDWAIT.
- Mid-read reset: assert `rst_n` = 0 in RDWAIT.
  - No `done` pulse.
  - `c0_rdata` returns to 0.
  - The next request is served normally.
